// File: rtl/juice_vendor.sv
// Multi-product vending controller: coin credit, priced selection, vend handshake, unit change return.
// Optional inactivity refund is compiled in with `define JUICE_TIMEOUT_EN.
module juice_vendor #(
  parameter int NUM_PRODUCTS = 2,
  parameter int CREDIT_W = 8,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICE_VEC = {8'd5, 8'd3},
  parameter int TIMEOUT_CYC = 1000,
  localparam int SEL_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    coin_valid,
  input  logic [CREDIT_W-1:0]     coin_value,
  input  logic                    sel_valid,
  input  logic [SEL_W-1:0]        sel_id,
  input  logic                    cancel,
  input  logic [NUM_PRODUCTS-1:0] sold_out,
  input  logic                    vend_ack,
  output logic                    vend_req,
  output logic [SEL_W-1:0]        vend_id,
  output logic                    change_pulse,
  output logic                    coin_reject,
  output logic                    sel_err,
  output logic [CREDIT_W-1:0]     credit,
  output logic                    busy
);

  localparam int TBL_N = 1 << SEL_W;

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  state_t              state_reg;
  logic [CREDIT_W-1:0] credit_reg;
  logic [SEL_W-1:0]    vend_id_reg;
  logic                vend_req_reg;
  logic                change_pulse_reg;
  logic                coin_reject_reg;
  logic                sel_err_reg;
  logic                busy_reg;

  // Tables are padded to a power of two so any sel_id indexes safely;
  // padding entries read as unavailable.
  logic [CREDIT_W-1:0] price_tbl [TBL_N];
  logic [TBL_N-1:0]    avail;

  genvar gi;
  generate
    for (gi = 0; gi < TBL_N; gi++) begin : g_tbl
      if (gi < NUM_PRODUCTS) begin : g_real
        assign price_tbl[gi] = PRICE_VEC[gi*CREDIT_W +: CREDIT_W];
        assign avail[gi]     = ~sold_out[gi];
      end else begin : g_pad
        assign price_tbl[gi] = '0;
        assign avail[gi]     = 1'b0;
      end
    end
  endgenerate

  logic [CREDIT_W-1:0] sel_price;
  logic                sel_ok;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic                timeout_hit;

  assign sel_price = price_tbl[sel_id];
  assign sel_ok    = avail[sel_id] && (credit_reg >= sel_price);
  assign coin_sum  = {1'b0, credit_reg} + {1'b0, coin_value};
  assign coin_fits = ~coin_sum[CREDIT_W];

`ifdef JUICE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_cnt_reg;

  assign timeout_hit = (state_reg == CREDIT) && (idle_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

  // Held at zero outside CREDIT, so every entry to CREDIT starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_reg <= '0;
    end else if (state_reg != CREDIT || sel_valid || (coin_valid && coin_fits)) begin
      idle_cnt_reg <= '0;
    end else if (!timeout_hit) begin
      idle_cnt_reg <= idle_cnt_reg + 1'b1;
    end
  end
`else
  logic timeout_unused;
  assign timeout_unused = ^TIMEOUT_CYC;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      credit_reg       <= '0;
      vend_id_reg      <= '0;
      vend_req_reg     <= 1'b0;
      change_pulse_reg <= 1'b0;
      coin_reject_reg  <= 1'b0;
      sel_err_reg      <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      coin_reject_reg <= 1'b0;
      sel_err_reg     <= 1'b0;
      case (state_reg)
        IDLE, CREDIT: begin
          if (cancel && state_reg == CREDIT) begin
            state_reg        <= CHANGE;
            change_pulse_reg <= 1'b1;
            busy_reg         <= 1'b1;
            coin_reject_reg  <= coin_valid;
          end else if (sel_valid) begin
            coin_reject_reg <= coin_valid;
            if (state_reg == CREDIT && sel_ok) begin
              credit_reg   <= credit_reg - sel_price;
              vend_id_reg  <= sel_id;
              vend_req_reg <= 1'b1;
              busy_reg     <= 1'b1;
              state_reg    <= VEND;
            end else begin
              sel_err_reg <= 1'b1;
            end
          end else if (timeout_hit) begin
            // Refund in progress; a coin arriving now is handed back.
            state_reg        <= CHANGE;
            change_pulse_reg <= 1'b1;
            busy_reg         <= 1'b1;
            coin_reject_reg  <= coin_valid;
          end else if (coin_valid) begin
            if (coin_fits) begin
              credit_reg <= coin_sum[CREDIT_W-1:0];
              if (coin_sum != '0) state_reg <= CREDIT;
            end else begin
              coin_reject_reg <= 1'b1;
            end
          end
        end
        VEND: begin
          coin_reject_reg <= coin_valid;
          sel_err_reg     <= sel_valid;
          if (vend_ack) begin
            vend_req_reg <= 1'b0;
            if (credit_reg != '0) begin
              state_reg        <= CHANGE;
              change_pulse_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end
        CHANGE: begin
          coin_reject_reg <= coin_valid;
          sel_err_reg     <= sel_valid;
          if (credit_reg != '0) credit_reg <= credit_reg - 1'b1;
          if (credit_reg <= CREDIT_W'(1)) begin
            state_reg        <= IDLE;
            change_pulse_reg <= 1'b0;
            busy_reg         <= 1'b0;
          end
        end
        default: begin
          state_reg        <= IDLE;
          credit_reg       <= '0;
          vend_req_reg     <= 1'b0;
          change_pulse_reg <= 1'b0;
          busy_reg         <= 1'b0;
        end
      endcase
    end
  end

  assign vend_req     = vend_req_reg;
  assign vend_id      = vend_id_reg;
  assign change_pulse = change_pulse_reg;
  assign coin_reject  = coin_reject_reg;
  assign sel_err      = sel_err_reg;
  assign credit       = credit_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_juice_vendor.sv
// Directed self-checking bench for juice_vendor (prices 3 and 5, plus a one-product instance).
module tb_juice_vendor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_valid;
  logic [7:0] coin_value;
  logic       sel_valid;
  logic [0:0] sel_id;
  logic       cancel;
  logic [1:0] sold_out;
  logic       vend_ack;

  logic       vend_req, change_pulse, coin_reject, sel_err, busy;
  logic [0:0] vend_id;
  logic [7:0] credit;

  logic       one_vend_req, one_change_pulse, one_coin_reject, one_sel_err, one_busy;
  logic [0:0] one_vend_id;
  logic [7:0] one_credit;

  int passed = 0;
  int total  = 0;
  int n;

  always #5 clk = ~clk;

  juice_vendor #(.TIMEOUT_CYC(20)) u_dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .sold_out(sold_out),
    .vend_ack(vend_ack), .vend_req(vend_req), .vend_id(vend_id),
    .change_pulse(change_pulse), .coin_reject(coin_reject), .sel_err(sel_err),
    .credit(credit), .busy(busy)
  );

  juice_vendor #(.NUM_PRODUCTS(1), .PRICE_VEC(8'd3), .TIMEOUT_CYC(20)) u_one (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .sold_out(sold_out[0]),
    .vend_ack(vend_ack), .vend_req(one_vend_req), .vend_id(one_vend_id),
    .change_pulse(one_change_pulse), .coin_reject(one_coin_reject), .sel_err(one_sel_err),
    .credit(one_credit), .busy(one_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic coin(input logic [7:0] v);
    coin_valid = 1'b1; coin_value = v;
    tick();
    coin_valid = 1'b0;
    $display("coin %0d -> credit %0d reject %0b", v, credit, coin_reject);
  endtask

  task automatic select(input logic [0:0] id);
    sel_valid = 1'b1; sel_id = id;
    tick();
    sel_valid = 1'b0;
    $display("select %0d -> vend_req %0b sel_err %0b credit %0d", id, vend_req, sel_err, credit);
  endtask

  task automatic ack();
    vend_ack = 1'b1;
    tick();
    vend_ack = 1'b0;
    $display("ack -> vend_req %0b change_pulse %0b credit %0d", vend_req, change_pulse, credit);
  endtask

  // Counts consecutive change_pulse cycles starting from the current cycle.
  task automatic count_pulses(input int limit, output int cnt);
    cnt = 0;
    for (int i = 0; i < limit && change_pulse === 1'b1; i++) begin
      cnt++;
      tick();
    end
    $display("refund -> %0d change pulses", cnt);
  endtask

  initial begin
    rst_n = 1'b0; coin_valid = 1'b0; coin_value = '0; sel_valid = 1'b0; sel_id = '0;
    cancel = 1'b0; sold_out = '0; vend_ack = 1'b0;
    tick(); tick();
    check("rst_vend_req", vend_req, 0);
    check("rst_vend_id", vend_id, 0);
    check("rst_credit", credit, 0);
    check("rst_busy", busy, 0);
    check("rst_change", change_pulse, 0);
    rst_n = 1'b1;
    tick();

    // Exact payment
    coin(8'd2);
    check("a_credit2", credit, 2);
    coin(8'd1);
    check("a_credit3", credit, 3);
    select(1'b0);
    check("a_vend_req", vend_req, 1);
    check("a_vend_id", vend_id, 0);
    check("a_credit_after", credit, 0);
    check("a_busy", busy, 1);
    tick(); tick(); tick();
    check("a_vend_held", vend_req, 1);
    ack();
    check("a_req_drop", vend_req, 0);
    check("a_busy_idle", busy, 0);
    count_pulses(10, n);
    check("a_pulses", n, 0);

    // Change return
    coin(8'd5);
    coin(8'd2);
    check("b_credit7", credit, 7);
    select(1'b0);
    check("b_credit4", credit, 4);
    check("b_vend_req", vend_req, 1);
    ack();
    check("b_req_drop", vend_req, 0);
    check("b_change_busy", busy, 1);
    count_pulses(20, n);
    check("b_pulses", n, 4);
    check("b_credit0", credit, 0);
    check("b_idle", busy, 0);

    // Selection refusals
    coin(8'd3);
    select(1'b1);
    check("c_sel_err_price", sel_err, 1);
    check("c_credit_kept", credit, 3);
    check("c_no_vend", vend_req, 0);
    check("c_one_range_err", one_sel_err, 1);
    check("c_one_credit", one_credit, 3);
    tick();
    check("c_sel_err_pulse", sel_err, 0);
    sold_out = 2'b01;
    select(1'b0);
    check("c_sel_err_sold", sel_err, 1);
    check("c_credit_sold", credit, 3);
    sold_out = 2'b00;
    cancel = 1'b1; tick(); cancel = 1'b0;
    count_pulses(20, n);
    check("c_refund", n, 3);
    check("c_credit0", credit, 0);

    // Overflow and contention
    coin(8'd250);
    check("d_credit250", credit, 250);
    coin(8'd10);
    check("d_reject", coin_reject, 1);
    check("d_credit_kept", credit, 250);
    cancel = 1'b1; sel_valid = 1'b1; sel_id = 1'b0; coin_valid = 1'b1; coin_value = 8'd1;
    tick();
    cancel = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0;
    check("d_contend_reject", coin_reject, 1);
    check("d_contend_sel_err", sel_err, 0);
    check("d_contend_vend", vend_req, 0);
    count_pulses(300, n);
    check("d_pulses", n, 250);
    check("d_credit0", credit, 0);

    // Busy rejection and asynchronous reset
    coin(8'd7);
    select(1'b1);
    check("e_credit2", credit, 2);
    coin(8'd3);
    check("e_vend_reject", coin_reject, 1);
    check("e_vend_credit", credit, 2);
    check("e_vend_held", vend_req, 1);
    ack();
    check("e_change", change_pulse, 1);
    #2 rst_n = 1'b0;
    #1;
    check("e_rst_change", change_pulse, 0);
    check("e_rst_credit", credit, 0);
    check("e_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    coin(8'd5);
    select(1'b1);
    check("e_vend_before_rst", vend_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("e_rst_vend_req", vend_req, 0);
    check("e_rst_vend_id", vend_id, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Inactivity
    coin(8'd2);
`ifdef JUICE_TIMEOUT_EN
    for (int i = 0; i < 19; i++) tick();
    check("f_still_credit", busy, 0);
    check("f_credit2", credit, 2);
    tick();
    check("f_timeout_change", change_pulse, 1);
    count_pulses(20, n);
    check("f_pulses", n, 2);
    check("f_credit0", credit, 0);
`else
    for (int i = 0; i < 100; i++) tick();
    check("f_credit_held", credit, 2);
    check("f_no_change", change_pulse, 0);
    check("f_not_busy", busy, 0);
    cancel = 1'b1; tick(); cancel = 1'b0;
    count_pulses(20, n);
    check("f_cancel_pulses", n, 2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
